// File: rtl/ula_serial_responder_pkg.sv
// Shared types and constants for the bit-serial ALU responder.
//   op_e    : operation code carried on the request channel
//   state_e : responder FSM state
//   FLAG_*  : bit positions inside the 4-bit {C,V,N,Z} flag vector
package ula_serial_responder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int unsigned FLAG_C   = 3;
  localparam int unsigned FLAG_V   = 2;
  localparam int unsigned FLAG_N   = 1;
  localparam int unsigned FLAG_Z   = 0;
  localparam int unsigned NumFlags = 4;

  // ADD/SUB go through the full adder and own the carry chain; AND/OR do not.
  function automatic logic is_arith(op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ula_serial_responder_if.sv
// Request/response channel bundle for ula_serial_responder.
//   master : operation issuer (drives request, consumes response)
//   slave  : the responder itself
//   req_*  : valid/ready request with op and two WIDTH-bit operands
//   rsp_*  : valid/ready response with WIDTH-bit result and {C,V,N,Z} flags
interface ula_serial_responder_if
  import ula_serial_responder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();

  logic                req_valid;
  logic                req_ready;
  op_e                 req_op;
  logic [WIDTH-1:0]    req_a;
  logic [WIDTH-1:0]    req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_result;
  logic [NumFlags-1:0] rsp_flags;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/ula_serial_responder_bit_slice.sv
// One-bit combinational ALU slice.
//   a_i, b_i : operand bits (b_i already inverted by the caller for SUB)
//   cin_i    : carry in
//   op_i     : operation
//   r_o      : result bit
//   cout_o   : carry out (always 0 for AND/OR)
module ula_serial_responder_bit_slice
  import ula_serial_responder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  input  op_e  op_i,
  output logic r_o,
  output logic cout_o
);

  always_comb begin
    r_o    = 1'b0;
    cout_o = 1'b0;
    unique case (op_i)
      OP_ADD, OP_SUB: begin
        r_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
      end
      OP_AND: r_o = a_i & b_i;
      OP_OR:  r_o = a_i | b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/ula_serial_responder.sv
// Bit-serial ALU responder: accepts one ADD/SUB/AND/OR request at a time, computes it one bit
// per clock LSB first through a single bit slice, then holds the result until it is taken.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; drops any in-flight operation
//   bus   : slave side of the request/response channel
module ula_serial_responder
  import ula_serial_responder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ula_serial_responder_if.slave bus
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e              state_q;
  op_e                 op_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    res_q;
  logic                carry_q;
  logic [CntW-1:0]     cnt_q;
  logic [NumFlags-1:0] flags_q;
  logic                req_ready_q;
  logic                rsp_valid_q;

  logic                slice_r;
  logic                slice_cout;
  logic                arith;
  logic [WIDTH-1:0]    res_d;
  logic [NumFlags-1:0] flags_d;

  // Operand shift registers present the current bit at index 0.
  ula_serial_responder_bit_slice u_slice (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .op_i  (op_q),
    .r_o   (slice_r),
    .cout_o(slice_cout)
  );

  // Flags only matter on the MSB step: carry_q then holds the carry into the MSB.
  always_comb begin
    arith           = is_arith(op_q);
    res_d           = {slice_r, res_q[WIDTH-1:1]};
    flags_d         = '0;
    flags_d[FLAG_C] = arith & slice_cout;
    flags_d[FLAG_V] = arith & (carry_q ^ slice_cout);
    flags_d[FLAG_N] = res_d[WIDTH-1];
    flags_d[FLAG_Z] = (res_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      flags_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            a_q         <= bus.req_a;
            // Subtraction is a + ~b + 1: invert b here and preset the carry.
            b_q         <= (bus.req_op == OP_SUB) ? ~bus.req_b : bus.req_b;
            carry_q     <= (bus.req_op == OP_SUB);
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          if (arith) begin
            carry_q <= slice_cout;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            flags_q     <= flags_d;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flags_q;

endmodule
